screen_sequencer: RTL and testbench

SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

---
 rtl/screen_sequencer_if.sv | 30 +++
 rtl/screen_sequencer.sv | 141 ++++++++++++++
 tb/tb_screen_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/screen_sequencer_if.sv
// rtl/screen_sequencer_if.sv - pixel/layer/request bundle for the screen sequencer
interface screen_sequencer_if;
    logic        frame_start;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        start_req;
    logic        over_req;
    logic        pause_req;
    logic        grid_print;
    logic [23:0] grid_rgb;
    logic        cell_print;
    logic [23:0] cell_rgb;
    logic        text_print;
    logic [23:0] text_rgb;
    logic [23:0] RGB;
    logic [1:0]  screen_state;
    logic        blink;

    modport master (
        output frame_start, x, y, start_req, over_req, pause_req,
        output grid_print, grid_rgb, cell_print, cell_rgb, text_print, text_rgb,
        input  RGB, screen_state, blink
    );

    modport slave (
        input  frame_start, x, y, start_req, over_req, pause_req,
        input  grid_print, grid_rgb, cell_print, cell_rgb, text_print, text_rgb,
        output RGB, screen_state, blink
    );
endinterface

// File: rtl/screen_sequencer.sv
// rtl/screen_sequencer.sv - game screen FSM, blink timer and layer compositor (optional PAUSE via SCREEN_SEQ_PAUSE_EN)
module screen_sequencer #(
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic [23:0] BG_RGB       = 24'h000000
) (
    input  logic              clk,
    input  logic              rst,
    screen_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_TITLE = 2'b00,
        ST_PLAY  = 2'b01,
        ST_OVER  = 2'b10,
        ST_PAUSE = 2'b11
    } state_t;

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        blink_q, blink_d;
    logic        start_pend_q, start_pend_d;
    logic        over_pend_q, over_pend_d;
    logic        pause_pend_q, pause_pend_d;
    logic [23:0] rgb_q, rgb_d;

    logic        start_eff;
    logic        over_eff;
    logic        pause_eff;
    logic        active;

`ifndef SCREEN_SEQ_PAUSE_EN
    // The pause request port stays on the interface but has no effect in this build.
    logic        unused_pause;
    assign unused_pause = bus.pause_req;
`endif

    // Screen state, sticky request flags and blink timer; all changes land on frame_start.
    always_comb begin
        start_eff = start_pend_q | bus.start_req;
        over_eff  = over_pend_q  | bus.over_req;
`ifdef SCREEN_SEQ_PAUSE_EN
        pause_eff = pause_pend_q | bus.pause_req;
`else
        pause_eff = 1'b0;
`endif
        state_d      = state_q;
        cnt_d        = cnt_q;
        blink_d      = blink_q;
        start_pend_d = start_eff;
        over_pend_d  = over_eff;
        pause_pend_d = pause_eff;

        if (bus.frame_start) begin
            // Every request, legal or not, is consumed by the frame boundary.
            start_pend_d = 1'b0;
            over_pend_d  = 1'b0;
            pause_pend_d = 1'b0;

            case (state_q)
                ST_TITLE: if (start_eff) state_d = ST_PLAY;
                ST_PLAY: begin
                    if (over_eff)       state_d = ST_OVER;
                    else if (pause_eff) state_d = ST_PAUSE;
                end
                ST_OVER:  if (start_eff) state_d = ST_TITLE;
`ifdef SCREEN_SEQ_PAUSE_EN
                ST_PAUSE: begin
                    if (over_eff)       state_d = ST_OVER;
                    else if (pause_eff) state_d = ST_PLAY;
                end
`endif
                default:  state_d = ST_TITLE;
            endcase

            if (state_d != state_q) begin
                // A new screen always opens with the blink phase visible.
                cnt_d   = 8'd0;
                blink_d = 1'b1;
            end else if (state_q != ST_PAUSE) begin
                if (cnt_q == BLINK_LAST) begin
                    cnt_d   = 8'd0;
                    blink_d = ~blink_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end
    end

    // Layer composition uses the state/blink of the same cycle as the pixel inputs.
    always_comb begin
        active = (bus.x < 10'd640) && (bus.y < 10'd480);
        rgb_d  = BG_RGB;
        case (state_q)
            ST_TITLE: begin
                if (bus.text_print && blink_q) rgb_d = bus.text_rgb;
            end
            ST_PLAY: begin
                if (bus.text_print)      rgb_d = bus.text_rgb;
                else if (bus.cell_print) rgb_d = bus.cell_rgb;
                else if (bus.grid_print) rgb_d = bus.grid_rgb;
            end
            ST_OVER: begin
                if (bus.text_print)                 rgb_d = bus.text_rgb;
                else if (bus.cell_print && blink_q) rgb_d = bus.cell_rgb;
                else if (bus.grid_print)            rgb_d = bus.grid_rgb;
            end
            default: begin
                if (bus.text_print)      rgb_d = bus.text_rgb;
                else if (bus.grid_print) rgb_d = bus.grid_rgb;
            end
        endcase
        if (!active) rgb_d = 24'h000000;
    end

    // State and output registers; reset wins over any same-cycle frame_start or request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_TITLE;
            cnt_q        <= 8'd0;
            blink_q      <= 1'b1;
            start_pend_q <= 1'b0;
            over_pend_q  <= 1'b0;
            pause_pend_q <= 1'b0;
            rgb_q        <= 24'h000000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            blink_q      <= blink_d;
            start_pend_q <= start_pend_d;
            over_pend_q  <= over_pend_d;
            pause_pend_q <= pause_pend_d;
            rgb_q        <= rgb_d;
        end
    end

    assign bus.RGB          = rgb_q;
    assign bus.screen_state = state_q;
    assign bus.blink        = blink_q;
endmodule

// File: tb/tb_screen_sequencer.sv
// tb/tb_screen_sequencer.sv - scoreboard bench for screen_sequencer
module tb_screen_sequencer;
    localparam logic [23:0] BG   = 24'h101010;
    localparam logic [23:0] TXT  = 24'h123456;
    localparam logic [23:0] CELL = 24'hFF0000;
    localparam logic [23:0] GRID = 24'h00FF00;
    localparam int K_RGB = 0;
    localparam int K_ST  = 1;
    localparam int K_BL  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    screen_sequencer_if sif ();

    screen_sequencer #(.BLINK_FRAMES(3), .BG_RGB(BG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    typedef struct {
        int          cyc;
        int          kind;
        logic [23:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in this cycle against the DUT outputs.
    exp_t        e;
    logic [23:0] act;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.kind == K_RGB)     act = sif.RGB;
            else if (e.kind == K_ST) act = {22'd0, sif.screen_state};
            else                     act = {23'd0, sif.blink};
            checks++;
            if (e.cyc != cyc || act !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)", e.name, act, e.val, cyc, e.cyc);
            end
        end
    end

    task automatic chk(input int kind, input logic [23:0] v, input string nm);
        exp_t n;
        n.cyc  = cyc;
        n.kind = kind;
        n.val  = v;
        n.name = nm;
        sb.push_back(n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sif.frame_start = 1'b0;
        sif.start_req   = 1'b0;
        sif.over_req    = 1'b0;
        sif.pause_req   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    bit pat [8] = '{1, 1, 0, 0, 0, 1, 1, 1};

    initial begin
        rst = 1'b1;
        sif.x = 10'd100;          sif.y = 10'd100;
        sif.frame_start = 1'b1;   sif.start_req = 1'b1;
        sif.over_req = 1'b1;      sif.pause_req = 1'b0;
        sif.grid_print = 1'b0;    sif.grid_rgb = GRID;
        sif.cell_print = 1'b0;    sif.cell_rgb = CELL;
        sif.text_print = 1'b0;    sif.text_rgb = TXT;
        tick();
        tick();
        chk(K_ST, 24'd0, "reset_state");
        chk(K_BL, 24'd1, "reset_blink");
        chk(K_RGB, 24'd0, "reset_rgb");

        // First pixel after release, then a mid-frame start request.
        rst = 1'b0;
        sif.text_print = 1'b1;
        tick();
        chk(K_RGB, TXT, "first_rgb_title_text");
        sif.start_req = 1'b1;
        tick();
        chk(K_ST, 24'd0, "start_midframe_hold");
        tick();
        chk(K_ST, 24'd0, "start_wait_frame");
        sif.frame_start = 1'b1;
        tick();
        chk(K_ST, 24'd1, "start_to_play");
        chk(K_BL, 24'd1, "play_blink");
        chk(K_RGB, TXT, "rgb_prev_state");

        // PLAY layer priority and active-area clipping.
        sif.text_print = 1'b0; sif.cell_print = 1'b1; sif.grid_print = 1'b1;
        tick();
        chk(K_RGB, CELL, "play_cell_over_grid");
        sif.x = 10'd640;
        tick();
        chk(K_RGB, 24'd0, "x640_black");
        sif.x = 10'd100; sif.y = 10'd480;
        tick();
        chk(K_RGB, 24'd0, "y480_black");
        sif.y = 10'd100; sif.cell_print = 1'b0;
        tick();
        chk(K_RGB, GRID, "play_grid");
        sif.grid_print = 1'b0;
        tick();
        chk(K_RGB, BG, "play_bg");
        sif.text_print = 1'b1; sif.cell_print = 1'b1;
        tick();
        chk(K_RGB, TXT, "play_text_top");
        sif.text_print = 1'b0; sif.cell_print = 1'b0;

        // Pause request in PLAY.
        sif.pause_req = 1'b1; sif.frame_start = 1'b1;
        tick();
`ifdef SCREEN_SEQ_PAUSE_EN
        chk(K_ST, 24'd3, "pause_enter");
        chk(K_BL, 24'd1, "pause_blink");
        sif.cell_print = 1'b1; sif.grid_print = 1'b1;
        tick();
        chk(K_RGB, GRID, "pause_cell_hidden");
        for (int i = 0; i < 5; i++) begin
            sif.frame_start = 1'b1;
            tick();
            chk(K_BL, 24'd1, "pause_blink_frozen");
            chk(K_ST, 24'd3, "pause_hold");
        end
        sif.pause_req = 1'b1; sif.frame_start = 1'b1;
        tick();
        chk(K_ST, 24'd1, "pause_exit");
        tick();
        chk(K_RGB, CELL, "resume_cell");
`else
        chk(K_ST, 24'd1, "pause_ignored");
        chk(K_BL, 24'd1, "pause_ignored_blink");
        sif.cell_print = 1'b1; sif.grid_print = 1'b1;
        tick();
        chk(K_RGB, CELL, "play_cell_after_pause");
`endif
        sif.cell_print = 1'b0; sif.grid_print = 1'b0;

        // Simultaneous over/start at frame_start: over wins, start is dropped.
        sif.start_req = 1'b1; sif.over_req = 1'b1; sif.frame_start = 1'b1;
        tick();
        chk(K_ST, 24'd2, "over_wins");
        chk(K_BL, 24'd1, "over_blink_set");
        sif.frame_start = 1'b1;
        tick();
        chk(K_ST, 24'd2, "start_discarded");
        chk(K_BL, 24'd1, "over_blink_f1");
        sif.cell_print = 1'b1;
        tick();
        chk(K_RGB, CELL, "over_cell_blink1");
        sif.frame_start = 1'b1;
        tick();
        chk(K_BL, 24'd1, "over_blink_f2");
        sif.frame_start = 1'b1;
        tick();
        chk(K_BL, 24'd0, "over_blink_f3");
        sif.grid_print = 1'b1;
        tick();
        chk(K_RGB, GRID, "over_cell_blink0");
        sif.cell_print = 1'b0; sif.grid_print = 1'b0;
        tick();
        chk(K_RGB, BG, "over_bg");
        sif.text_print = 1'b1;
        tick();
        chk(K_RGB, TXT, "over_text");
        sif.text_print = 1'b0;

        // OVER ignores over_req, leaves on start.
        sif.over_req = 1'b1; sif.frame_start = 1'b1;
        tick();
        chk(K_ST, 24'd2, "over_ignores_over");
        sif.start_req = 1'b1;
        tick();
        sif.frame_start = 1'b1;
        tick();
        chk(K_ST, 24'd0, "over_to_title");
        chk(K_BL, 24'd1, "title_blink_set");

        // Blink sequence in TITLE with BLINK_FRAMES=3.
        sif.text_print = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sif.frame_start = 1'b1;
            tick();
            chk(K_BL, {23'd0, pat[i]}, "blink_pattern");
            tick();
            chk(K_RGB, pat[i] ? TXT : BG, "title_text_blink");
        end

        // Illegal over_req in TITLE is discarded at the frame boundary.
        sif.over_req = 1'b1;
        tick();
        sif.frame_start = 1'b1;
        tick();
        chk(K_ST, 24'd0, "title_ignores_over");
        sif.start_req = 1'b1; sif.frame_start = 1'b1;
        tick();
        chk(K_ST, 24'd1, "title_to_play");
        sif.frame_start = 1'b1;
        tick();
        chk(K_ST, 24'd1, "over_not_stale");

        // Reset together with over_req and frame_start.
        rst = 1'b1; sif.over_req = 1'b1; sif.frame_start = 1'b1;
        tick();
        chk(K_ST, 24'd0, "rst_state");
        chk(K_RGB, 24'd0, "rst_rgb");
        chk(K_BL, 24'd1, "rst_blink");
        rst = 1'b0; sif.frame_start = 1'b1;
        tick();
        chk(K_ST, 24'd0, "rst_no_pending");
        chk(K_RGB, TXT, "rst_first_rgb");

        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
